// File: rtl/score_display_pkg.sv
// Shared types and constants for the game-score display path: the
// converter FSM states, default sizes and the decimal range helpers.
package score_display_pkg;

  localparam int IN_WIDTH_DEF = 16;
  localparam int DIGITS_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest value that fits in `digits` decimal digits (10^digits - 1).
  function automatic longint unsigned max_val(input int digits);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

  // Saturation pattern: every BCD digit set to 9, digit 0 in bits [3:0].
  function automatic logic [63:0] all_nines(input int digits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with start/busy/done handshake and saturation above the display range.
module score_bcd_converter
  import score_display_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF,
  parameter int DIGITS   = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int                BCD_W      = 4 * DIGITS;
  localparam int                CNT_W      = $clog2(IN_WIDTH + 1);
  localparam longint unsigned   MAX_VAL    = max_val(DIGITS);
  localparam logic [63:0]       NINES_WIDE = all_nines(DIGITS);
  localparam logic [BCD_W-1:0]  NINES      = NINES_WIDE[BCD_W-1:0];

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]    acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                overflow_q, overflow_d;
  logic                in_range;

  assign in_range = (64'(bin_in) <= MAX_VAL);

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  // Handshake outputs are registered, so they trail the state by one edge;
  // busy_q also masks start during the done cycle, when state is IDLE again.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    busy_d     = (state_q != IDLE);
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          bin_d   = bin_in;
          acc_d   = '0;
          cnt_d   = CNT_W'(IN_WIDTH);
          ovf_d   = !in_range;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ovf_q) begin
          state_d = DONE;
        end else begin
          {acc_d, bin_d} = {acc_adj, bin_q} << 1;
          cnt_d          = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        bcd_d      = ovf_q ? NINES : acc_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the combinational block above uses blocking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;

endmodule
